model_scalar_tanh_function: RTL and testbench
=============================================

MODEL_SCALAR_TANH_FUNCTION -- requirements
Module: model_scalar_tanh_function

Interface
REQ-001 Parameter: DATA_SIZE, default 64, IEEE-754 double word width carried as bit vectors.
REQ-002 Parameter: CONTROL_SIZE, default 64, width of the internal wait-cycle counter.
REQ-003 Port: CLK, in, 1, single clock; all state updates on rising edge.
REQ-004 Port: RST, in, 1, reset; asynchronous, active-low.
REQ-005 Port: START, in, 1, request pulse; sampled only in STARTER_STATE.
REQ-006 Port: READY, out, 1, one-cycle result-valid pulse.
REQ-007 Port: DATA_IN, in, DATA_SIZE, operand x as real bits.
REQ-008 Port: DATA_OUT, out, DATA_SIZE, tanh(x) as real bits.
REQ-009 Port: OVERFLOW_OUT, out, 1, error flag, valid with READY.
REQ-010 Port: SINH_START and COSH_START, out, 1 each, start pulses to the downstream sinh and cosh units.
REQ-011 Port: SINH_DATA_IN and COSH_DATA_IN, out, DATA_SIZE each, operand forwarded to each unit.
REQ-012 Port: SINH_READY and COSH_READY, in, 1 each, completion pulses from the units.
REQ-013 Port: SINH_DATA_OUT and COSH_DATA_OUT, in, DATA_SIZE each, unit results as real bits.
REQ-014 Port: SINH_OVERFLOW_OUT and COSH_OVERFLOW_OUT, in, 1 each, unit error flags.

Function
REQ-015 The FSM SHALL have three states: STARTER_STATE, WAIT_STATE and ENDER_STATE.
REQ-016 In STARTER_STATE with START=1, the block SHALL:
- latch DATA_IN;
- drive SINH_DATA_IN and COSH_DATA_IN with DATA_IN;
- pulse SINH_START and COSH_START high for exactly one cycle;
- clear both done flags and the counter;
- go to WAIT_STATE.
REQ-017 START SHALL be ignored in WAIT_STATE and ENDER_STATE; there is no queuing.
REQ-018 In WAIT_STATE, a SINH_READY pulse SHALL set sinh_done and latch SINH_DATA_OUT and SINH_OVERFLOW_OUT.
REQ-019 In WAIT_STATE, a COSH_READY pulse SHALL set cosh_done and latch COSH_DATA_OUT and COSH_OVERFLOW_OUT.
REQ-020 SINH_READY and COSH_READY SHALL be accepted in any order, including the same cycle.
REQ-021 A second READY pulse from a unit already done SHALL be ignored; the first captured value is kept.
REQ-022 The block SHALL go to ENDER_STATE in the cycle after both done flags are set.
REQ-023 The counter SHALL increment every WAIT_STATE cycle and saturate at all-ones.
REQ-024 If the counter reaches all-ones with either flag clear, the block SHALL go to ENDER_STATE with timeout set.
REQ-025 In ENDER_STATE, DATA_OUT SHALL be realtobits(sinh_real / cosh_real), with operands taken from the latched bits.
REQ-026 In ENDER_STATE, OVERFLOW_OUT SHALL be 1 if any of the following hold, else 0:
- sinh overflow latched;
- cosh overflow latched;
- timeout;
- latched cosh real equals 0.0.
REQ-027 If latched cosh equals 0.0 or timeout is set, DATA_OUT SHALL be ZERO_DATA.
REQ-028 In ENDER_STATE, READY SHALL go high for one cycle, and the FSM SHALL return to STARTER_STATE.
REQ-029 READY SHALL deassert in the next STARTER_STATE cycle.
REQ-030 DATA_OUT and OVERFLOW_OUT SHALL hold their values until the next ENDER_STATE.
REQ-031 Latency from START to READY SHALL be 3 cycles plus the later unit's latency, where unit latency is cycles from the *_START pulse to its *_READY pulse.
REQ-032 The block SHALL be a simulation model using real arithmetic; synthesis is not a goal.

Reset
REQ-033 While RST=0 the block SHALL immediately force:
- DATA_OUT = ZERO_DATA, OVERFLOW_OUT = 0, READY = 0;
- SINH_START = COSH_START = 0;
- SINH_DATA_IN = COSH_DATA_IN = ZERO_DATA;
- done flags, timeout and counter cleared;
- FSM to STARTER_STATE.
REQ-034 Reset asserted mid-operation SHALL abandon the operation; unit READY pulses arriving after reset release SHALL be ignored in STARTER_STATE.

Verification
REQ-035 x=0x0000000000000000, sinh=0.0, cosh=1.0 -> DATA_OUT=0x0000000000000000, OVERFLOW_OUT=0, one READY pulse.
REQ-036 x=1.0 (0x3FF0000000000000), SINH_READY 2 cycles before COSH_READY -> DATA_OUT=0x3FE85EFAB514F394 (0.7615941559557649), OVERFLOW_OUT=0.
REQ-037 Both unit READYs in the same cycle, COSH_OVERFLOW_OUT=1 -> OVERFLOW_OUT=1, READY pulses once, exactly 1 cycle after entering ENDER_STATE.
REQ-038 START held high for 10 cycles while both units stall for 5 cycles -> exactly one SINH_START and one COSH_START pulse, exactly one READY.
REQ-039 RST driven low in WAIT_STATE, late COSH_READY after release -> all outputs at reset values, no READY, FSM stays in STARTER_STATE.
REQ-040 CONTROL_SIZE=4, COSH_READY never arrives -> READY after the 15-cycle timeout, OVERFLOW_OUT=1, DATA_OUT=ZERO_DATA.

Source files
------------

// File: rtl/model_scalar_tanh_function.sv
// ============================================================================
// model_scalar_tanh_function
// Computes tanh(x) as sinh(x)/cosh(x). The sinh and cosh values come from two
// external units. This is a real-arithmetic simulation model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module model_scalar_tanh_function #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic [DATA_SIZE-1:0] DATA_IN,
  output logic [DATA_SIZE-1:0] DATA_OUT,
  output logic                 OVERFLOW_OUT,
  output logic                 SINH_START,
  output logic                 COSH_START,
  output logic [DATA_SIZE-1:0] SINH_DATA_IN,
  output logic [DATA_SIZE-1:0] COSH_DATA_IN,
  input  logic                 SINH_READY,
  input  logic                 COSH_READY,
  input  logic [DATA_SIZE-1:0] SINH_DATA_OUT,
  input  logic [DATA_SIZE-1:0] COSH_DATA_OUT,
  input  logic                 SINH_OVERFLOW_OUT,
  input  logic                 COSH_OVERFLOW_OUT
);

  localparam logic [DATA_SIZE-1:0]    c_zero_data = '0;
  localparam logic [CONTROL_SIZE-1:0] c_count_one = {{(CONTROL_SIZE-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    STARTER_STATE = 2'd0,
    WAIT_STATE    = 2'd1,
    ENDER_STATE   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic                    r_ready;
  logic [DATA_SIZE-1:0]    r_data_out;
  logic                    r_overflow;
  logic                    r_sinh_start;
  logic                    r_cosh_start;
  logic [DATA_SIZE-1:0]    r_sinh_data_in;
  logic [DATA_SIZE-1:0]    r_cosh_data_in;
  logic                    r_sinh_done;
  logic                    r_cosh_done;
  logic [DATA_SIZE-1:0]    r_sinh_bits;
  logic [DATA_SIZE-1:0]    r_cosh_bits;
  logic                    r_sinh_ovf;
  logic                    r_cosh_ovf;
  logic                    r_timeout;
  logic [CONTROL_SIZE-1:0] r_count;

  logic                    w_both_done;
  logic                    w_count_max;
  logic                    w_cosh_zero;
  logic [DATA_SIZE-1:0]    w_quot_bits;

  assign w_both_done = r_sinh_done && r_cosh_done;
  assign w_count_max = (r_count == {CONTROL_SIZE{1'b1}});

  // Comparing as reals treats both +0.0 and -0.0 as a zero divisor.
  always_comb begin
    w_cosh_zero = ($bitstoreal(r_cosh_bits) == 0.0);
    w_quot_bits = $realtobits($bitstoreal(r_sinh_bits) / $bitstoreal(r_cosh_bits));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= STARTER_STATE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      STARTER_STATE: if (START) w_state_next = WAIT_STATE;
      WAIT_STATE:    if (w_both_done || w_count_max) w_state_next = ENDER_STATE;
      ENDER_STATE:   w_state_next = STARTER_STATE;
      default:       w_state_next = STARTER_STATE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ready        <= 1'b0;
      r_data_out     <= c_zero_data;
      r_overflow     <= 1'b0;
      r_sinh_start   <= 1'b0;
      r_cosh_start   <= 1'b0;
      r_sinh_data_in <= c_zero_data;
      r_cosh_data_in <= c_zero_data;
      r_sinh_done    <= 1'b0;
      r_cosh_done    <= 1'b0;
      r_sinh_bits    <= c_zero_data;
      r_cosh_bits    <= c_zero_data;
      r_sinh_ovf     <= 1'b0;
      r_cosh_ovf     <= 1'b0;
      r_timeout      <= 1'b0;
      r_count        <= '0;
    end else begin
      r_sinh_start <= 1'b0;
      r_cosh_start <= 1'b0;
      case (r_state)
        STARTER_STATE: begin
          r_ready <= 1'b0;
          if (START) begin
            r_sinh_data_in <= DATA_IN;
            r_cosh_data_in <= DATA_IN;
            r_sinh_start   <= 1'b1;
            r_cosh_start   <= 1'b1;
            r_sinh_done    <= 1'b0;
            r_cosh_done    <= 1'b0;
            r_sinh_bits    <= c_zero_data;
            r_cosh_bits    <= c_zero_data;
            r_sinh_ovf     <= 1'b0;
            r_cosh_ovf     <= 1'b0;
            r_timeout      <= 1'b0;
            r_count        <= '0;
          end
        end
        WAIT_STATE: begin
          // Only the first completion pulse of each unit is captured.
          if (SINH_READY && !r_sinh_done) begin
            r_sinh_done <= 1'b1;
            r_sinh_bits <= SINH_DATA_OUT;
            r_sinh_ovf  <= SINH_OVERFLOW_OUT;
          end
          if (COSH_READY && !r_cosh_done) begin
            r_cosh_done <= 1'b1;
            r_cosh_bits <= COSH_DATA_OUT;
            r_cosh_ovf  <= COSH_OVERFLOW_OUT;
          end
          if (!w_count_max) r_count <= r_count + c_count_one;
          if (!w_both_done && w_count_max) r_timeout <= 1'b1;
        end
        ENDER_STATE: begin
          r_ready    <= 1'b1;
          r_data_out <= (r_timeout || w_cosh_zero) ? c_zero_data : w_quot_bits;
          r_overflow <= r_sinh_ovf || r_cosh_ovf || r_timeout || w_cosh_zero;
        end
        default: ;
      endcase
    end
  end

  assign READY        = r_ready;
  assign DATA_OUT     = r_data_out;
  assign OVERFLOW_OUT = r_overflow;
  assign SINH_START   = r_sinh_start;
  assign COSH_START   = r_cosh_start;
  assign SINH_DATA_IN = r_sinh_data_in;
  assign COSH_DATA_IN = r_cosh_data_in;

endmodule

`default_nettype wire

// File: tb/tb_model_scalar_tanh_function.sv
// Testbench for model_scalar_tanh_function: the sinh/cosh units are emulated
// with programmable latency, and results are scoreboarded against a reference model.
`default_nettype none

module tb_model_scalar_tanh_function;

  localparam int DW = 64;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic [DW-1:0] DATA_IN = '0;
  logic          SINH_READY = 1'b0;
  logic          COSH_READY = 1'b0;
  logic [DW-1:0] SINH_DATA_OUT = '0;
  logic [DW-1:0] COSH_DATA_OUT = '0;
  logic          SINH_OVERFLOW_OUT = 1'b0;
  logic          COSH_OVERFLOW_OUT = 1'b0;
  logic          READY;
  logic [DW-1:0] DATA_OUT;
  logic          OVERFLOW_OUT;
  logic          SINH_START;
  logic          COSH_START;
  logic [DW-1:0] SINH_DATA_IN;
  logic [DW-1:0] COSH_DATA_IN;

  model_scalar_tanh_function #(.DATA_SIZE(DW), .CONTROL_SIZE(CW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY),
    .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .OVERFLOW_OUT(OVERFLOW_OUT),
    .SINH_START(SINH_START), .COSH_START(COSH_START),
    .SINH_DATA_IN(SINH_DATA_IN), .COSH_DATA_IN(COSH_DATA_IN),
    .SINH_READY(SINH_READY), .COSH_READY(COSH_READY),
    .SINH_DATA_OUT(SINH_DATA_OUT), .COSH_DATA_OUT(COSH_DATA_OUT),
    .SINH_OVERFLOW_OUT(SINH_OVERFLOW_OUT), .COSH_OVERFLOW_OUT(COSH_OVERFLOW_OUT)
  );

  always #5 CLK = ~CLK;

  // Latency -1 means the unit never answers; dup is the cycle of a second, bogus sinh pulse.
  typedef struct {
    logic [DW-1:0] x;
    logic [DW-1:0] s;
    logic [DW-1:0] c;
    bit            sov;
    bit            cov;
    int            sl;
    int            cl;
    int            dup;
    int            hold;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    bit            ov;
    int            lat;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input real x, input int sl, input int cl,
                              input bit sov, input bit cov, input int dup, input int hold);
    vec_t v;
    v.x = $realtobits(x);
    v.s = $realtobits($sinh(x));
    v.c = $realtobits($cosh(x));
    v.sov = sov; v.cov = cov; v.sl = sl; v.cl = cl; v.dup = dup; v.hold = hold;
    return v;
  endfunction

  function automatic exp_t model(input vec_t v);
    exp_t e;
    real  sr, cr;
    sr = $bitstoreal(v.s);
    cr = $bitstoreal(v.c);
    if (v.sl < 0 || v.cl < 0) begin
      e.data = '0; e.ov = 1'b1; e.lat = (1 << CW) + 1;
    end else begin
      e.lat = 3 + ((v.sl > v.cl) ? v.sl : v.cl);
      if (cr == 0.0) begin
        e.data = '0; e.ov = 1'b1;
      end else begin
        e.data = $realtobits(sr / cr); e.ov = v.sov | v.cov;
      end
    end
    return e;
  endfunction

  task automatic chk_reset_values(input string tag);
    chk({tag, "_data_out"}, DATA_OUT, 64'h0);
    chk({tag, "_overflow"}, 64'(OVERFLOW_OUT), 64'h0);
    chk({tag, "_ready"}, 64'(READY), 64'h0);
    chk({tag, "_sinh_start"}, 64'(SINH_START), 64'h0);
    chk({tag, "_cosh_start"}, 64'(COSH_START), 64'h0);
    chk({tag, "_sinh_data_in"}, SINH_DATA_IN, 64'h0);
    chk({tag, "_cosh_data_in"}, COSH_DATA_IN, 64'h0);
  endtask

  task automatic run_op(input vec_t v, input string tag);
    exp_t e;
    int   n_s = 0;
    int   n_c = 0;
    bit   is_dup;
    exp_q.push_back(model(v));
    @(negedge CLK);
    START = 1'b1;
    DATA_IN = v.x;
    for (int k = 0; k < 26; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        chk({tag, "_sinh_data_in"}, SINH_DATA_IN, v.x);
        chk({tag, "_cosh_data_in"}, COSH_DATA_IN, v.x);
      end
      if (SINH_START) n_s++;
      if (COSH_START) n_c++;
      if (READY) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL %s_extra_ready: got READY at cycle %0d expected none", tag, k);
        end else begin
          e = exp_q.pop_front();
          chk({tag, "_data"}, DATA_OUT, e.data);
          chk({tag, "_ovf"}, 64'(OVERFLOW_OUT), 64'(e.ov));
          chk({tag, "_latency"}, 64'(k), 64'(e.lat));
        end
      end
      is_dup = (v.dup > 0) && (k == v.dup);
      START = (k + 1 < v.hold);
      SINH_READY = (k == v.sl) || is_dup;
      SINH_DATA_OUT = is_dup ? $realtobits(5.0) : v.s;
      SINH_OVERFLOW_OUT = is_dup ? 1'b1 : v.sov;
      COSH_READY = (k == v.cl);
      COSH_DATA_OUT = v.c;
      COSH_OVERFLOW_OUT = v.cov;
    end
    chk({tag, "_pending_results"}, 64'(exp_q.size()), 64'h0);
    chk({tag, "_sinh_start_pulses"}, 64'(n_s), 64'h1);
    chk({tag, "_cosh_start_pulses"}, 64'(n_c), 64'h1);
    exp_q.delete();
  endtask

  initial begin
    real t;
    int  n_r;
    int  n_s;

    tbl[0] = mk(0.0, 1, 1, 1'b0, 1'b0, 0, 1);
    tbl[1] = mk(1.0, 2, 4, 1'b0, 1'b0, 0, 1);
    tbl[2] = mk(-0.5, 5, 2, 1'b0, 1'b0, 0, 1);
    tbl[3] = mk(2.0, 3, 3, 1'b0, 1'b1, 0, 1);
    tbl[4] = mk(0.25, 1, 5, 1'b0, 1'b0, 3, 1);
    tbl[5] = mk(0.75, 7, 7, 1'b0, 1'b0, 0, 10);
    tbl[6] = mk(0.3, 2, 3, 1'b0, 1'b0, 0, 1);
    tbl[6].c = '0;
    tbl[7] = mk(3.0, 4, 1, 1'b1, 1'b0, 0, 1);
    tbl[8] = mk(1.5, 2, -1, 1'b0, 1'b0, 0, 1);

    #1 RST = 1'b0;
    #1 chk_reset_values("reset");
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i], $sformatf("vec%0d", i));
      if (i == 1) begin
        t = $bitstoreal(DATA_OUT) - 0.7615941559557649;
        if (t < 0.0) t = -t;
        checks++;
        if (t > 1.0e-15) begin
          errors++;
          $display("FAIL tanh1_value: got %h expected about 3fe85efab514f394", DATA_OUT);
        end
      end
    end

    // Abandon an operation in WAIT_STATE, then feed late unit pulses.
    @(negedge CLK);
    START = 1'b1;
    DATA_IN = $realtobits(0.9);
    @(negedge CLK);
    START = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1 chk_reset_values("midreset");
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    SINH_READY = 1'b1; SINH_DATA_OUT = $realtobits(1.0);
    COSH_READY = 1'b1; COSH_DATA_OUT = $realtobits(2.0);
    @(negedge CLK);
    SINH_READY = 1'b0;
    COSH_READY = 1'b0;
    n_r = 0;
    n_s = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (READY) n_r++;
      if (SINH_START || COSH_START) n_s++;
    end
    chk("midreset_no_ready", 64'(n_r), 64'h0);
    chk("midreset_no_start", 64'(n_s), 64'h0);
    chk("midreset_data_hold", DATA_OUT, 64'h0);
    chk("midreset_ovf_hold", 64'(OVERFLOW_OUT), 64'h0);

    run_op(tbl[1], "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
